// File: rtl/token_run_decoder.sv
// Serial doubled-token run decoder: counts runs of '1', pushes floor(len/2) into a 4-deep FIFO.
// Optional odd-length check enabled by defining TOKEN_RUN_DECODER_ODD_CHECK_EN.
module token_run_decoder (
    input  logic       clk,
    input  logic       rst,
    input  logic       d,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_tokens,
    output logic       run_overflow,
    output logic       fifo_overflow,
    output logic       odd_error
);
    localparam int       DEPTH   = 4;
    localparam logic [8:0] CNT_MAX = 9'd401;

    logic [8:0] cnt_q, cnt_d;
    logic [7:0] mem_q [DEPTH];
    logic [1:0] wr_q, rd_q;
    logic [2:0] occ_q, occ_d;
    logic       rov_q, fov_q;
    logic       run_end, push, pop, full, accept;

    always_comb begin
        run_end = !d && (cnt_q != 9'd0);
        // A run that hit the saturation value is an overflow and never decodes.
        push    = run_end && (cnt_q != CNT_MAX);
        pop     = out_valid && out_ready;
        full    = (occ_q == 3'(DEPTH));
        accept  = push && (!full || pop);
        if (d) cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 9'd1;
        else   cnt_d = 9'd0;
        occ_d = occ_q;
        case ({accept, pop})
            2'b10:   occ_d = occ_q + 3'd1;
            2'b01:   occ_d = occ_q - 3'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 9'd0;
            wr_q  <= 2'd0;
            rd_q  <= 2'd0;
            occ_q <= 3'd0;
            rov_q <= 1'b0;
            fov_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            occ_q <= occ_d;
            if (cnt_d == CNT_MAX) rov_q <= 1'b1;
            if (push && !accept)  fov_q <= 1'b1;
            if (accept)           wr_q  <= wr_q + 2'd1;
            if (pop)              rd_q  <= rd_q + 2'd1;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (!rst && accept) mem_q[wr_q] <= cnt_q[8:1];
    end

    assign out_valid     = (occ_q != 3'd0);
    assign out_tokens    = out_valid ? mem_q[rd_q] : 8'd0;
    assign run_overflow  = rov_q;
    assign fifo_overflow = fov_q;

`ifdef TOKEN_RUN_DECODER_ODD_CHECK_EN
    logic odd_q;
    always_ff @(posedge clk) begin
        if (rst)                    odd_q <= 1'b0;
        else if (push && cnt_q[0])  odd_q <= 1'b1;
    end
    assign odd_error = odd_q;
`else
    assign odd_error = 1'b0;
`endif
endmodule

// File: tb/tb_token_run_decoder.sv
// Directed bench for token_run_decoder: vector table plus hand-written multi-cycle sequences.
module tb_token_run_decoder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       d = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [7:0] out_tokens;
    logic       run_overflow, fifo_overflow, odd_error;

`ifdef TOKEN_RUN_DECODER_ODD_CHECK_EN
    localparam logic ODD = 1'b1;
`else
    localparam logic ODD = 1'b0;
`endif

    token_run_decoder dut (
        .clk(clk), .rst(rst), .d(d),
        .out_valid(out_valid), .out_ready(out_ready), .out_tokens(out_tokens),
        .run_overflow(run_overflow), .fifo_overflow(fifo_overflow), .odd_error(odd_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic       r, dd, rdy, ev;
        logic [7:0] et;
        logic       ct, eodd;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    task automatic add(input string nm, input logic r, input logic dd, input logic rdy,
                       input logic ev, input logic [7:0] et, input logic ct, input logic eodd);
        vec_t v;
        v.nm = nm; v.r = r; v.dd = dd; v.rdy = rdy; v.ev = ev; v.et = et; v.ct = ct; v.eodd = eodd;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic dd, input logic rdy);
        rst = r; d = dd; out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int len, input logic rdy);
        for (int i = 0; i < len; i++) step(1'b0, 1'b1, rdy);
        step(1'b0, 1'b0, rdy);
    endtask

    initial begin
        // reset state
        add("reset", 1, 0, 0, 0, 8'd0, 1, 0);
        // d=1,1,0 with ready -> valid for exactly one cycle, tokens 1
        add("r27_a", 0, 1, 1, 0, 8'd0, 0, 0);
        add("r27_b", 0, 1, 1, 0, 8'd0, 0, 0);
        add("r27_c", 0, 0, 1, 1, 8'd1, 1, 0);
        add("r27_d", 0, 0, 1, 0, 8'd0, 0, 0);
        // runs 4, 6, 2 held, then drained in order 2, 3, 1
        for (int i = 0; i < 4; i++) add("r28_l4", 0, 1, 0, 0, 8'd0, 0, 0);
        add("r28_e4", 0, 0, 0, 1, 8'd2, 1, 0);
        for (int i = 0; i < 6; i++) add("r28_l6", 0, 1, 0, 1, 8'd2, 1, 0);
        add("r28_e6", 0, 0, 0, 1, 8'd2, 1, 0);
        add("r28_l2", 0, 1, 0, 1, 8'd2, 1, 0);
        add("r28_l2", 0, 1, 0, 1, 8'd2, 1, 0);
        add("r28_e2", 0, 0, 0, 1, 8'd2, 1, 0);
        add("r28_p1", 0, 0, 1, 1, 8'd3, 1, 0);
        add("r28_p2", 0, 0, 1, 1, 8'd1, 1, 0);
        add("r28_p3", 0, 0, 1, 0, 8'd0, 0, 0);
        // odd run of 3 -> floor value 1, odd flag only with the macro
        add("r31_a", 0, 1, 0, 0, 8'd0, 0, 0);
        add("r31_b", 0, 1, 0, 0, 8'd0, 0, 0);
        add("r31_c", 0, 1, 0, 0, 8'd0, 0, 0);
        add("r31_e", 0, 0, 0, 1, 8'd1, 1, ODD);
        add("r31_p", 0, 0, 1, 0, 8'd0, 0, ODD);
        // reset mid-run discards the partial count
        for (int i = 0; i < 5; i++) add("r32_l5", 0, 1, 0, 0, 8'd0, 0, ODD);
        add("r32_rst", 1, 0, 0, 0, 8'd0, 1, 0);
        add("r32_a", 0, 1, 0, 0, 8'd0, 0, 0);
        add("r32_b", 0, 1, 0, 0, 8'd0, 0, 0);
        add("r32_e", 0, 0, 0, 1, 8'd1, 1, 0);
        add("r32_p", 0, 0, 1, 0, 8'd0, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].dd, vecs[i].rdy);
            chk({vecs[i].nm, "_valid"}, int'(out_valid), int'(vecs[i].ev));
            if (vecs[i].ct) chk({vecs[i].nm, "_tokens"}, int'(out_tokens), int'(vecs[i].et));
            chk({vecs[i].nm, "_rov"}, int'(run_overflow), 0);
            chk({vecs[i].nm, "_fov"}, int'(fifo_overflow), 0);
            chk({vecs[i].nm, "_odd"}, int'(odd_error), int'(vecs[i].eodd));
        end

        // five runs of 2 while stalled -> overflow, four entries of 1 survive
        begin
            int n;
            step(1, 0, 0);
            for (int i = 0; i < 4; i++) run(2, 0);
            chk("r29_full_nofov", int'(fifo_overflow), 0);
            run(2, 0);
            chk("r29_fov", int'(fifo_overflow), 1);
            n = 0;
            for (int i = 0; i < 10; i++) begin
                out_ready = 1'b1;
                #1;
                if (out_valid) begin
                    chk("r29_tok", int'(out_tokens), 1);
                    n++;
                end
                step(0, 0, 1);
            end
            chk("r29_count", n, 4);
            chk("r29_fov_sticky", int'(fifo_overflow), 1);
        end

        // push and pop together on a full FIFO: both happen, no overflow
        step(1, 0, 0);
        run(2, 0); run(4, 0); run(6, 0); run(8, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 0);
        step(0, 0, 1);
        chk("r19_valid", int'(out_valid), 1);
        chk("r19_head", int'(out_tokens), 2);
        chk("r19_fov", int'(fifo_overflow), 0);
        step(0, 0, 1); chk("r19_t3", int'(out_tokens), 3);
        step(0, 0, 1); chk("r19_t4", int'(out_tokens), 4);
        step(0, 0, 1); chk("r19_t5", int'(out_tokens), 5);
        step(0, 0, 1); chk("r19_empty", int'(out_valid), 0);

        // 400 ones decode to 200; 401 ones overflow and push nothing
        step(1, 0, 0);
        run(400, 0);
        chk("r30_400_valid", int'(out_valid), 1);
        chk("r30_400_tok", int'(out_tokens), 200);
        chk("r30_400_rov", int'(run_overflow), 0);
        step(0, 0, 1);
        chk("r30_pop", int'(out_valid), 0);
        for (int i = 0; i < 400; i++) step(0, 1, 0);
        chk("r30_400_norov", int'(run_overflow), 0);
        step(0, 1, 0);
        chk("r30_401_rov", int'(run_overflow), 1);
        step(0, 0, 0);
        chk("r30_401_nopush", int'(out_valid), 0);
        run(2, 0);
        chk("r30_after_valid", int'(out_valid), 1);
        chk("r30_after_tok", int'(out_tokens), 1);
        chk("r30_rov_sticky", int'(run_overflow), 1);
        step(1, 0, 0);
        chk("r30_rst_rov", int'(run_overflow), 0);
        chk("r30_rst_valid", int'(out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/token_run_decoder.md
TOKEN_RUN_DECODER -- requirements
Module: token_run_decoder

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port d  input  1  serial doubled-token stream, sampled every clk edge.
REQ-004 SHALL have port out_valid  output  1  FIFO head holds a decoded token count.
REQ-005 SHALL have port out_ready  input  1  consumer accepts the head entry when out_valid=1.
REQ-006 SHALL have port out_tokens  output  8  decoded token count at the FIFO head, range 0..200.
REQ-007 SHALL have port run_overflow  output  1  sticky: a run of '1' longer than 400 bits was seen.
REQ-008 SHALL have port fifo_overflow  output  1  sticky: a decoded count was dropped because the FIFO was full.
REQ-009 SHALL have port odd_error  output  1  sticky: a run of odd length was seen (present only with the macro, see REQ-025).

Function
REQ-010 SHALL count consecutive d=1 samples in a 9-bit run counter; the counter saturates at 401.
REQ-011 SHALL end a run at the first edge that samples d=0 while the run counter is nonzero, then clear the counter to 0 on that same edge.
REQ-012 SHALL, at run end with count L<=400, push floor(L/2) into a 4-entry FIFO.
REQ-013 SHALL set run_overflow when the counter reaches 401; a run ending with the counter at 401 SHALL push nothing.
REQ-014 SHALL not push anything for d=0 samples taken while the counter is 0; idle zeros are ignored.
REQ-015 SHALL assert out_valid whenever the FIFO is non-empty; out_tokens SHALL equal the oldest entry and stay stable until it is popped.
REQ-016 SHALL pop the head on every edge where out_valid=1 and out_ready=1.
REQ-017 SHALL give latency 1: a run ending at edge N, with the FIFO empty, makes out_valid=1 in the cycle after edge N.
REQ-018 SHALL, on a push into a full FIFO with no pop on the same edge, drop the new entry, keep the stored ones, and set fifo_overflow.
REQ-019 SHALL, on a push and a pop on the same edge, perform both; a full FIFO then accepts the new entry and occupancy is unchanged.
REQ-020 SHALL leave out_tokens don't-care when out_valid=0; the bench SHALL not check it then.
REQ-021 SHALL not clear any sticky flag by any input other than rst; run counting and FIFO operation continue after a flag is set.

Reset
REQ-022 SHALL, on rst=1 at an edge, clear the run counter, empty the FIFO, and clear run_overflow, fifo_overflow and odd_error.
REQ-023 SHALL drive out_valid=0 in the cycle after reset; out_tokens SHALL read 0.
REQ-024 SHALL discard a partially counted run when rst is asserted mid-run; the first run after reset counts from 0.

Configuration
REQ-025 SHALL implement the odd-length check only when TOKEN_RUN_DECODER_ODD_CHECK_EN is defined: odd_error is set sticky at any run end with odd L<=400. The floor value is still pushed.
REQ-026 SHALL, without TOKEN_RUN_DECODER_ODD_CHECK_EN, tie odd_error to constant 0 and contain no parity logic.

Verification
REQ-027 SHALL cover: d=1,1,0 with out_ready=1 -> out_valid=1 for one cycle after the 0 sample, with out_tokens=1.
REQ-028 SHALL cover: three runs of lengths 4, 6 and 2 with out_ready=0, then out_ready=1 -> out_tokens 2, 3, 1 in order, then out_valid=0.
REQ-029 SHALL cover: five runs of length 2 with out_ready=0 -> after the fifth run fifo_overflow=1; popping the FIFO yields exactly four entries of 1.
REQ-030 SHALL cover: 400 ones then a 0 -> out_tokens=200 with run_overflow=0; 401 ones then a 0 -> no push and run_overflow=1, which stays set until rst.
REQ-031 SHALL cover: with the macro defined, a run of 3 -> out_tokens=1 and odd_error=1; without the macro, the same stimulus -> out_tokens=1 and odd_error=0.
REQ-032 SHALL cover: rst asserted after 5 ones, then d=1,1,0 -> single entry with out_tokens=1 and all flags 0.
